// File: rtl/morse_symbol_sequencer.sv
// Morse key timer: classifies presses as dot/dash and walks the symbol tree.
// Define MORSE_STUCK_KEY_EN to force the error state on an over-long press.
module morse_symbol_sequencer #(
    parameter int CNT_W     = 16,
    parameter int MIN_PRESS = 2,
    parameter int DOT_MAX   = 4,
    parameter int CHAR_GAP  = 6,
    parameter int WORD_GAP  = 14
`ifdef MORSE_STUCK_KEY_EN
    ,
    parameter int STUCK_MAX = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] cur_state,
    input  logic [5:0] dot_next,
    input  logic [5:0] dash_next,
    output logic       char_valid,
    output logic [5:0] char_code,
    output logic       char_err,
    output logic       word_space,
    output logic       busy
);

    localparam logic [5:0] ERR_STATE = 6'b101000;
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] CHAR_C = CNT_W'(CHAR_GAP - 1);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_GAP - CHAR_GAP - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WORD_WAIT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             key_meta;
    logic             key_s;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       tree_nx;
    logic             emit;
    logic             space;
    logic             classify;
    logic             stuck_hit;

`ifdef MORSE_STUCK_KEY_EN
    localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_MAX);
    logic stuck;

    // Once stuck, the eventual release is not classified again.
    assign classify  = !stuck;
    assign stuck_hit = (state == PRESS) && key_s && !stuck && (cnt == STUCK_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stuck <= 1'b0;
        end else if (state_nx != PRESS) begin
            stuck <= 1'b0;
        end else if (stuck_hit) begin
            stuck <= 1'b1;
        end
    end
`else
    assign classify  = 1'b1;
    assign stuck_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end

    // Counter restarts on every state change and saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= '0;
            char_valid <= 1'b0;
            char_code  <= '0;
            char_err   <= 1'b0;
            word_space <= 1'b0;
        end else begin
            cur_state  <= tree_nx;
            char_valid <= emit;
            word_space <= space;
            if (emit) begin
                char_code <= cur_state;
                char_err  <= (cur_state == ERR_STATE);
            end
        end
    end

    always_comb begin
        state_nx = state;
        tree_nx  = cur_state;
        emit     = 1'b0;
        space    = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_s) begin
                    state_nx = PRESS;
                end
            end
            PRESS: begin
                if (!key_s) begin
                    state_nx = GAP;
                    if (classify) begin
                        if (cnt < MIN_C) begin
                            if (cur_state == 6'd0) begin
                                state_nx = IDLE;
                            end
                        end else if (cnt < DOT_C) begin
                            tree_nx = dot_next;
                        end else begin
                            tree_nx = dash_next;
                        end
                    end
                end else if (stuck_hit) begin
                    tree_nx = ERR_STATE;
                end
            end
            GAP: begin
                if (key_s) begin
                    state_nx = PRESS;
                end else if (cnt == CHAR_C) begin
                    emit     = 1'b1;
                    tree_nx  = '0;
                    state_nx = WORD_WAIT;
                end
            end
            WORD_WAIT: begin
                if (key_s) begin
                    state_nx = PRESS;
                end else if (cnt == WORD_C) begin
                    space    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer with a heap-indexed symbol tree.
// Honours MORSE_STUCK_KEY_EN for the stuck-key scenario.
module tb_morse_symbol_sequencer;

`ifdef MORSE_STUCK_KEY_EN
    localparam int TB_CNT_W = 8;
`else
    localparam int TB_CNT_W = 4;
`endif
    localparam logic [5:0] ERR = 6'b101000;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic [5:0] cur_state;
    logic [5:0] dot_next;
    logic [5:0] dash_next;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_err;
    logic       word_space;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Tree: dot -> 2s+1, dash -> 2s+2; beyond node 14 is the error node.
    function automatic logic [5:0] tree(input logic [5:0] s, input logic dash);
        int v;
        if (s == ERR) return ERR;
        v = 2 * int'(s) + 1 + int'(dash);
        if (v > 14) return ERR;
        return 6'(v);
    endfunction

    assign dot_next  = tree(cur_state, 1'b0);
    assign dash_next = tree(cur_state, 1'b1);

    morse_symbol_sequencer #(
        .CNT_W(TB_CNT_W),
        .MIN_PRESS(2),
        .DOT_MAX(4),
        .CHAR_GAP(6),
        .WORD_GAP(14)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .cur_state(cur_state),
        .dot_next(dot_next),
        .dash_next(dash_next),
        .char_valid(char_valid),
        .char_code(char_code),
        .char_err(char_err),
        .word_space(word_space),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Key high for k cycles; returns on the cycle the key drops.
    task automatic press(input int k);
        key = 1'b1;
        repeat (k) step();
        key = 1'b0;
    endtask

    task automatic drain();
        repeat (12) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b1;
        repeat (4) step();
        n_cmp++;
        if ({cur_state, char_valid, char_code, char_err, word_space, busy} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {cur_state, char_valid, char_code, char_err, word_space, busy});
        end
        reset = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_sync_delay: busy got %b want 0", busy);
        end
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_press_entry: busy got %b want 1", busy);
        end
        reset = 1'b1;
        step();
        key   = 1'b0;
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_dash();
        press(5);
        repeat (3) step();
        n_cmp++;
        if (cur_state !== 6'd2) begin
            n_bad++;
            $display("FAIL dash_state: got %b want %b", cur_state, 6'd2);
        end
        repeat (5) step();
        n_cmp++;
        if (char_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dash_early_valid: got %b want 0", char_valid);
        end
        step();
        n_cmp++;
        if ({char_valid, char_code, char_err} !== {1'b1, 6'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL dash_emit: got %b want %b",
                     {char_valid, char_code, char_err}, {1'b1, 6'd2, 1'b0});
        end
        step();
        n_cmp++;
        if ({char_valid, cur_state, char_code} !== {1'b0, 6'd0, 6'd2}) begin
            n_bad++;
            $display("FAIL dash_hold: got %b want %b",
                     {char_valid, cur_state, char_code}, {1'b0, 6'd0, 6'd2});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        press(5);
        repeat (3) step();
        n_cmp++;
        if (cur_state !== 6'd2) begin
            n_bad++;
            $display("FAIL b2b_first: got %b want %b", cur_state, 6'd2);
        end
        press(5);
        repeat (3) step();
        n_cmp++;
        if (cur_state !== 6'd6) begin
            n_bad++;
            $display("FAIL b2b_second: got %b want %b", cur_state, 6'd6);
        end
        repeat (6) step();
        n_cmp++;
        if ({char_valid, char_code, char_err} !== {1'b1, 6'd6, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_emit: got %b want %b",
                     {char_valid, char_code, char_err}, {1'b1, 6'd6, 1'b0});
        end
        repeat (7) step();
        n_cmp++;
        if (word_space !== 1'b0) begin
            n_bad++;
            $display("FAIL word_early: got %b want 0", word_space);
        end
        step();
        n_cmp++;
        if ({word_space, char_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL word_pulse: got %b want 100", {word_space, char_valid, busy});
        end
        step();
        n_cmp++;
        if (word_space !== 1'b0) begin
            n_bad++;
            $display("FAIL word_one_cycle: got %b want 0", word_space);
        end
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int pulses;
        int moved;
        pulses = 0;
        moved  = 0;
        press(1);
        repeat (20) begin
            step();
            if (char_valid) pulses++;
            if (cur_state != 6'd0) moved++;
        end
        n_cmp++;
        if ({pulses, moved, 31'd0, busy} !== 96'd0) begin
            n_bad++;
            $display("FAIL glitch_idle: pulses %0d moves %0d busy %b want 0 0 0",
                     pulses, moved, busy);
        end
        press(3);
        repeat (3) step();
        n_cmp++;
        if (cur_state !== 6'd1) begin
            n_bad++;
            $display("FAIL glitch_dot: got %b want %b", cur_state, 6'd1);
        end
        press(1);
        pulses = 0;
        moved  = 0;
        repeat (8) begin
            step();
            if (char_valid) pulses++;
            if (cur_state != 6'd1) moved++;
        end
        n_cmp++;
        if (pulses != 0 || moved != 0) begin
            n_bad++;
            $display("FAIL glitch_gap: pulses %0d moves %0d want 0 0", pulses, moved);
        end
        step();
        n_cmp++;
        if ({char_valid, char_code} !== {1'b1, 6'd1}) begin
            n_bad++;
            $display("FAIL glitch_gap_emit: got %b want %b",
                     {char_valid, char_code}, {1'b1, 6'd1});
        end
        drain();
    endtask

    task automatic test_error_seq();
        int lens [5];
        logic [5:0] want [5];
        lens = '{3, 5, 3, 5, 3};
        want = '{6'd1, 6'd4, 6'd9, ERR, ERR};
        for (int i = 0; i < 5; i++) begin
            press(lens[i]);
            repeat (3) step();
            n_cmp++;
            if (cur_state !== want[i]) begin
                n_bad++;
                $display("FAIL err_seq[%0d]: got %b want %b", i, cur_state, want[i]);
            end
        end
        repeat (6) step();
        n_cmp++;
        if ({char_valid, char_code, char_err} !== {1'b1, ERR, 1'b1}) begin
            n_bad++;
            $display("FAIL err_emit: got %b want %b",
                     {char_valid, char_code, char_err}, {1'b1, ERR, 1'b1});
        end
        drain();
    endtask

    task automatic test_long_dash();
        press(20);
        repeat (3) step();
        n_cmp++;
        if (cur_state !== 6'd2) begin
            n_bad++;
            $display("FAIL long_dash: got %b want %b", cur_state, 6'd2);
        end
        repeat (6) step();
        n_cmp++;
        if ({char_valid, char_code, char_err} !== {1'b1, 6'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL long_emit: got %b want %b",
                     {char_valid, char_code, char_err}, {1'b1, 6'd2, 1'b0});
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        press(5);
        repeat (3) step();
        press(5);
        repeat (4) step();
        n_cmp++;
        if (cur_state !== 6'd6) begin
            n_bad++;
            $display("FAIL mid_state: got %b want %b", cur_state, 6'd6);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cur_state, busy, char_code} !== 13'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want 0", {cur_state, busy, char_code});
        end
        step();
        reset = 1'b0;
        repeat (20) begin
            step();
            if (char_valid || word_space) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL mid_no_pulse: got %0d want 0", pulses);
        end
    endtask

`ifdef MORSE_STUCK_KEY_EN
    task automatic test_stuck();
        press(70);
        n_cmp++;
        if (cur_state !== ERR) begin
            n_bad++;
            $display("FAIL stuck_state: got %b want %b", cur_state, ERR);
        end
        repeat (9) step();
        n_cmp++;
        if ({char_valid, char_code, char_err} !== {1'b1, ERR, 1'b1}) begin
            n_bad++;
            $display("FAIL stuck_emit: got %b want %b",
                     {char_valid, char_code, char_err}, {1'b1, ERR, 1'b1});
        end
        drain();
    endtask
`endif

    initial begin
        reset = 1'b1;
        key   = 1'b0;
        test_reset();
        test_single_dash();
        test_back_to_back();
        test_glitch();
        test_error_seq();
        test_long_dash();
        test_reset_mid();
`ifdef MORSE_STUCK_KEY_EN
        test_stuck();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
